// File: rtl/bn_multidigit_updown_counter.sv
// Multi-digit base-BASE up/down counter with ripple carry/borrow, parallel load and terminal count.
// Optional build macro BN_COUNTER_SATURATE_EN: saturate at the terminal count instead of wrapping.
module bn_multidigit_updown_counter #(
  parameter  int BASE   = 3,
  parameter  int DIGITS = 4,
  localparam int W      = (BASE < 3) ? 1 : $clog2(BASE)
) (
  input  logic                clock,
  input  logic                reset_,
  input  logic                ei,
  input  logic                up,
  input  logic                ld,
  input  logic [DIGITS*W-1:0] d,
  output logic [DIGITS*W-1:0] q,
  output logic                eu,
  output logic                ld_err
);

  localparam logic [W-1:0] MAXD   = W'(BASE - 1);
  localparam logic [W:0]   BASE_X = (W + 1)'(BASE);

  logic [DIGITS*W-1:0] r_q;
  logic                r_ld_err;

  logic [DIGITS*W-1:0] w_next_cnt;
  logic [DIGITS*W-1:0] w_next_ld;
  logic                w_ld_bad;
  logic                w_carry;
  logic [W-1:0]        w_dig;
  logic [W-1:0]        w_ddig;
  logic                w_dig_max;
  logic                w_dig_zero;

  // An out-of-range digit counts as BASE-1 going up and as 0 going down, so a step repairs it.
  always_comb begin
    w_next_cnt = r_q;
    w_next_ld  = '0;
    w_ld_bad   = 1'b0;
    w_carry    = ei;
    w_dig      = '0;
    w_ddig     = '0;
    w_dig_max  = 1'b0;
    w_dig_zero = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      w_dig      = r_q[i*W +: W];
      w_dig_max  = (w_dig == MAXD) || ({1'b0, w_dig} >= BASE_X);
      w_dig_zero = (w_dig == '0)   || ({1'b0, w_dig} >= BASE_X);
      if (w_carry) begin
        if (up) w_next_cnt[i*W +: W] = w_dig_max  ? '0   : w_dig + 1'b1;
        else    w_next_cnt[i*W +: W] = w_dig_zero ? MAXD : w_dig - 1'b1;
      end
      w_carry = w_carry & (up ? w_dig_max : w_dig_zero);

      w_ddig = d[i*W +: W];
      if ({1'b0, w_ddig} < BASE_X) w_next_ld[i*W +: W] = w_ddig;
      else                         w_ld_bad = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_) begin
      r_q      <= '0;
      r_ld_err <= 1'b0;
    end else if (ld) begin
      r_q      <= w_next_ld;
      r_ld_err <= w_ld_bad;
    end else begin
      r_ld_err <= 1'b0;
`ifdef BN_COUNTER_SATURATE_EN
      if (ei && !w_carry) r_q <= w_next_cnt;
`else
      if (ei) r_q <= w_next_cnt;
`endif
    end
  end

  assign q      = r_q;
  assign eu     = w_carry;
  assign ld_err = r_ld_err;

endmodule
